gate_input_conditioner: RTL

- Two-channel input conditioner that sits directly upstream of the 2-input logic gate stage.
- Each channel passes raw, asynchronous, possibly bouncing A/B levels through a synchronizer and a counter-based debouncer.
- Outputs are clean, registered A/B levels for the gate, plus one-cycle rising-edge pulses and a settled flag.

---
 rtl/gate_input_conditioner.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gate_input_conditioner.sv
// rtl/gate_input_conditioner.sv - two-channel synchronizer + debouncer feeding a 2-input gate stage
//
// Purpose : Conditions two raw asynchronous, possibly bouncing levels (A_in, B_in)
//           into clean registered levels (A, B) for a downstream 2-input gate.
//           Also produces one-cycle rising-edge pulses and a settled flag.
// Ports   : clk      - single clock, all logic on rising edge
//           rst      - synchronous active-high reset
//           A_in     - raw asynchronous level, channel A
//           B_in     - raw asynchronous level, channel B
//           A, B     - debounced registered levels
//           A_rise   - one-cycle pulse after A goes 0->1
//           B_rise   - one-cycle pulse after B goes 0->1
//           settled  - high when both channels are in STABLE (combinational)
//           glitch_cnt_A/B [7:0] - saturating count of aborted changes
//                      (present only when GATE_INPUT_GLITCH_CNT_EN is defined)
// Macro   : GATE_INPUT_GLITCH_CNT_EN enables the glitch counters.

module gate_input_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    output logic       level,
    output logic       rise,
    output logic       stable
`ifdef GATE_INPUT_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic {ST_STABLE = 1'b0, ST_PENDING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a single-sample debounce there is nothing to wait for: flip in STABLE.
    localparam bit FLIP_NOW = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   out_d;
    logic                   abort;

    assign s = sync_q[SYNC_STAGES-1];

    // State register plus the registered datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= out_d;
            // Registered together with level so the pulse lines up with the new level.
            rise    <= out_d & ~level;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STABLE: begin
                if ((s != level) && !FLIP_NOW) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if ((s == level) || (cnt_q == CNT_MAX)) state_d = ST_STABLE;
            end
            default: state_d = ST_STABLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        cnt_d = cnt_q;
        out_d = level;
        abort = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s != level) begin
                    if (FLIP_NOW) out_d = ~level;
                    else          cnt_d = CNT_W'(1);
                end
            end
            ST_PENDING: begin
                if (s == level) begin
                    // Input bounced back before the count completed.
                    cnt_d = '0;
                    abort = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    out_d = ~level;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign stable = (state_q == ST_STABLE);

`ifdef GATE_INPUT_GLITCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt <= 8'd0;
        end else if (abort && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

module gate_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A_in,
    input  logic       B_in,
    output logic       A,
    output logic       B,
    output logic       A_rise,
    output logic       B_rise,
    output logic       settled
`ifdef GATE_INPUT_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_A,
    output logic [7:0] glitch_cnt_B
`endif
);

    logic a_stable;
    logic b_stable;

    gate_input_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_a (
        .clk       (clk),
        .rst       (rst),
        .raw       (A_in),
        .level     (A),
        .rise      (A_rise),
        .stable    (a_stable)
`ifdef GATE_INPUT_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt_A)
`endif
    );

    gate_input_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_b (
        .clk       (clk),
        .rst       (rst),
        .raw       (B_in),
        .level     (B),
        .rise      (B_rise),
        .stable    (b_stable)
`ifdef GATE_INPUT_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt_B)
`endif
    );

    assign settled = a_stable & b_stable;

endmodule
